// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter around a shared 32-bit bitwise logic unit.
// One operation in flight; the registered result is held until its owner takes it.

module lu_lane #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (op)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = ~(a | b);
        endcase
    end
endmodule

module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);
    typedef enum logic {IDLE, RESP} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } lu_req_t;

    state_t                  state;
    logic                    rr;
    logic                    owner;
    lu_req_t [1:0]           req;
    logic [1:0][WIDTH-1:0]   lane_y;
    logic                    gnt_idx;

    assign req[0] = {req_op0, req_a0, req_b0};
    assign req[1] = {req_op1, req_a1, req_b1};

    // Both lanes evaluate every cycle; only the granted one is captured.
    for (genvar k = 0; k < 2; k++) begin : g_lane
        lu_lane #(.WIDTH(WIDTH)) u_lane (
            .op (req[k].op),
            .a  (req[k].a),
            .b  (req[k].b),
            .y  (lane_y[k])
        );
    end

    // Ready is held low during reset even though it is combinational.
    always_comb begin
        req_ready = 2'b00;
        if (resetn && state == IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = rr ? 2'b10 : 2'b01;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign gnt_idx = req_ready[1];
    assign busy    = (state != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rr         <= 1'b0;
            owner      <= 1'b0;
            resp_valid <= 2'b00;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        resp_data  <= lane_y[gnt_idx];
                        owner      <= gnt_idx;
                        resp_valid <= req_ready;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    // Non-owner resp_ready is deliberately ignored.
                    if (resp_ready[owner]) begin
                        resp_valid <= 2'b00;
                        rr         <= ~owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a grant/fairness model pushes expected
// responses into a queue, an independent monitor pops and checks them.

module tb_logic_unit_arbiter;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0 = 2'b00, req_op1 = 2'b00;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b00;
    logic [31:0] resp_data;
    logic        busy;

    logic_unit_arbiter #(.WIDTH(32)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
        .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lop(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    typedef struct {
        bit          k;
        logic [31:0] d;
        int          stamp;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: who is favoured, whether a result is outstanding, and for whom.
    bit m_busy  = 0;
    bit m_rr    = 0;
    bit m_owner = 0;

    always @(negedge clock) begin
        logic [1:0] er;
        exp_t e;
        if (resetn) begin
            er = 2'b00;
            if (!m_busy) begin
                if (req_valid == 2'b01)      er = 2'b01;
                else if (req_valid == 2'b10) er = 2'b10;
                else if (req_valid == 2'b11) er = m_rr ? 2'b10 : 2'b01;
            end
            check("req_ready", {30'd0, req_ready}, {30'd0, er});
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            if (m_busy) begin
                if (resp_ready[m_owner]) begin
                    m_busy = 0;
                    m_rr   = ~m_owner;
                end
            end else if (er != 2'b00) begin
                e.k     = er[1];
                e.d     = er[1] ? lop(req_op1, req_a1, req_b1) : lop(req_op0, req_a0, req_b0);
                e.stamp = cyc;
                exp_q.push_back(e);
                m_busy  = 1;
                m_owner = er[1];
            end
        end
    end

    // Monitor: pairs each presented response with the oldest expectation.
    bit          holding = 0;
    bit          acc_chk = 0;
    logic [1:0]  hv;
    logic [31:0] hd;

    always @(negedge clock) begin
        exp_t e;
        if (resetn) begin
            if (acc_chk) begin
                check("resp_clear", {30'd0, resp_valid}, 32'd0);
                acc_chk = 0;
            end else if (holding) begin
                check("resp_hold_valid", {30'd0, resp_valid}, {30'd0, hv});
                check("resp_hold_data", resp_data, hd);
            end else if (resp_valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", {30'd0, resp_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_valid", {30'd0, resp_valid}, e.k ? 32'd2 : 32'd1);
                    check("resp_data", resp_data, e.d);
                    check("resp_latency", cyc, e.stamp + 1);
                    holding = 1;
                    hv = e.k ? 2'b10 : 2'b01;
                    hd = e.d;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].stamp + 1) begin
                check("resp_missing", {30'd0, resp_valid}, exp_q[0].k ? 32'd2 : 32'd1);
                void'(exp_q.pop_front());
            end
            if (holding && (resp_ready & hv) != 2'b00) begin
                holding = 0;
                acc_chk = 1;
            end
        end
    end

    task automatic step(output logic [1:0] hs);
        @(negedge clock);
        hs = req_valid & req_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (k == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
        else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
    endtask

    task automatic wait_hs(input int k, input string name);
        logic [1:0] hs;
        int n = 0;
        do begin step(hs); n++; end while (!hs[k] && n < 20);
        check(name, {31'd0, hs[k]}, 32'd1);
    endtask

    // Issue one op, wait for its grant, then check the response against a constant.
    task automatic issue(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        load(k, op, a, b);
        req_valid[k] = 1'b1;
        wait_hs(k, {name, "_grant"});
        req_valid[k] = 1'b0;
        @(negedge clock);
        check({name, "_valid"}, {30'd0, resp_valid}, (k == 1) ? 32'd2 : 32'd1);
        check({name, "_data"}, resp_data, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        logic [1:0] hs;
        for (int i = 0; i < n; i++) step(hs);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  hs;
        logic [1:0]  ops [4];
        logic [31:0] exps [4];
        bit          got [4];
        int          gcyc [3];
        int          cnt, n;
        bit          pv [2];

        // Reset values
        #1;
        check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready_valid", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b00;
        repeat (2) @(posedge clock);
        #2 resetn = 1'b1;
        @(posedge clock);
        #1;

        // 1: single OR on port 0
        resp_ready = 2'b11;
        issue(0, 2'b01, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF, "single_or");
        check("single_busy_after", {31'd0, busy}, 32'd0);

        // 2: every opcode on port 1
        ops  = '{2'b00, 2'b01, 2'b10, 2'b11};
        exps = '{32'h0F00_0F00, 32'hFF0F_FF0F, 32'hF00F_F00F, 32'h00F0_00F0};
        for (int i = 0; i < 4; i++)
            issue(1, ops[i], 32'hFF00_FF00, 32'h0F0F_0F0F, exps[i], $sformatf("op%0d", i));

        // 3: sustained contention alternates grants
        load(0, 2'($urandom), $urandom, $urandom);
        load(1, 2'($urandom), $urandom, $urandom);
        req_valid = 2'b11;
        cnt = 0; n = 0;
        while (cnt < 4 && n < 40) begin
            step(hs); n++;
            if (hs != 2'b00) begin
                got[cnt] = hs[1];
                cnt++;
                load(int'(hs[1]), 2'($urandom), $urandom, $urandom);
                if (cnt == 4) req_valid = 2'b00;
            end
        end
        req_valid = 2'b00;
        check("contention_count", cnt, 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("contention_order%0d", i), {31'd0, got[i]}, i % 2);
        idle(3);

        // 4: backpressure on port 0 while port 1 waits
        resp_ready = 2'b10;
        load(0, 2'b10, 32'hDEAD_BEEF, 32'h1234_5678);
        req_valid = 2'b01;
        wait_hs(0, "bp_grant");
        load(1, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F);
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step(hs);
            check("bp_no_grant", {30'd0, hs}, 32'd0);
        end
        resp_ready = 2'b11;
        wait_hs(1, "bp_late_grant");
        req_valid = 2'b00;
        idle(3);

        // 5: asynchronous reset during RESP
        resp_ready = 2'b00;
        load(0, 2'b01, 32'hAAAA_0000, 32'h0000_5555);
        req_valid = 2'b01;
        wait_hs(0, "rst_mid_grant");
        req_valid = 2'b00;
        step(hs);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_resp_valid", {30'd0, resp_valid}, 32'd0);
        check("rst_mid_resp_data", resp_data, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        m_busy = 0; m_rr = 0; m_owner = 0;
        holding = 0; acc_chk = 0;
        load(0, 2'b10, $urandom, $urandom);
        load(1, 2'b11, $urandom, $urandom);
        req_valid = 2'b11;
        @(posedge clock);
        #2 resetn = 1'b1;
        resp_ready = 2'b11;
        step(hs);
        check("rst_first_grant", {30'd0, hs}, 32'd1);
        req_valid = 2'b10;
        wait_hs(1, "rst_second_grant");
        req_valid = 2'b00;
        idle(3);

        // 6: lone requester back-to-back, then contention favours port 0
        load(1, 2'($urandom), $urandom, $urandom);
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            cnt = 0;
            do begin step(hs); cnt++; end while (!hs[1] && cnt < 20);
            check("lone_grant", {31'd0, hs[1]}, 32'd1);
            gcyc[i] = cyc;
            load(1, 2'($urandom), $urandom, $urandom);
        end
        check("lone_gap1", gcyc[1] - gcyc[0], 32'd2);
        check("lone_gap2", gcyc[2] - gcyc[1], 32'd2);
        load(0, 2'b00, $urandom, $urandom);
        req_valid = 2'b11;
        cnt = 0;
        do begin step(hs); cnt++; end while (hs == 2'b00 && cnt < 20);
        check("lone_then_both", {30'd0, hs}, 32'd1);
        req_valid = 2'b00;
        idle(3);

        // Random traffic with withdrawals and random backpressure
        pv[0] = 0; pv[1] = 0;
        hs = 2'b00;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (pv[k] && hs[k]) pv[k] = 0;
                if (!pv[k]) begin
                    if ($urandom_range(2) == 0) begin
                        pv[k] = 1;
                        load(k, 2'($urandom), $urandom, $urandom);
                    end
                end else if ($urandom_range(15) == 0) begin
                    pv[k] = 0;
                end
                req_valid[k] = pv[k];
            end
            resp_ready = 2'($urandom);
            step(hs);
        end
        req_valid = 2'b00;
        resp_ready = 2'b11;
        idle(4);
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
